// File: rtl/load_store_pkg.sv
// Shared load/store encodings: access size codes and the skid-buffer
// occupancy states, reused by the load formatter and the store-merge unit.
package load_store_pkg;

   localparam logic [1:0] SZ_WORD = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_BYTE = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skidState_t;

endpackage

// File: rtl/load_lane_format.sv
// Combinational load formatter: picks the addressed byte/half lane,
// zero- or sign-extends it, and flags accesses that break alignment.
module load_lane_format
   import load_store_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFS_W  = $clog2(DATA_W / 8)
) (
   input  logic [DATA_W-1:0] data,
   input  logic [OFS_W-1:0]  ofs,
   input  logic [1:0]        size,
   input  logic              isSigned,
   output logic [DATA_W-1:0] fmtData,
   output logic              misaligned
);

   localparam logic [OFS_W-1:0] OFS_ONE      = OFS_W'(1);
   localparam logic [OFS_W-1:0] OFS_ZERO     = OFS_W'(0);
   localparam logic [OFS_W-1:0] HALF_MAX_OFS = OFS_W'(DATA_W / 8 - 2);

   logic [7:0]       loByte_s;
   logic [7:0]       hiByte_s;
   logic [OFS_W-1:0] hiOfs_s;
   logic             halfBad_s;

   // Lane extraction, extension and alignment check for one load
   always_comb begin
      fmtData    = '0;
      misaligned = 1'b0;
      // The upper half byte wraps within the word; a wrapped lane is always flagged misaligned.
      loByte_s   = data[{ofs, 3'b000} +: 8];
      hiOfs_s    = ofs + OFS_ONE;
      hiByte_s   = data[{hiOfs_s, 3'b000} +: 8];
      halfBad_s  = ofs[0] | (ofs > HALF_MAX_OFS);
      case (size)
         SZ_BYTE: begin
            fmtData    = {{(DATA_W-8){isSigned & loByte_s[7]}}, loByte_s};
            misaligned = 1'b0;
         end
         SZ_HALF: begin
            misaligned = halfBad_s;
            if (halfBad_s) begin
               fmtData = '0;
            end else begin
               fmtData = {{(DATA_W-16){isSigned & hiByte_s[7]}}, hiByte_s, loByte_s};
            end
         end
         default: begin
            misaligned = (ofs != OFS_ZERO);
            if (ofs != OFS_ZERO) begin
               fmtData = '0;
            end else begin
               fmtData = data;
            end
         end
      endcase
   end

endmodule

// File: rtl/load_align_unit.sv
// MEM/WB load-data formatter with a two-entry skid buffer so WB stalls never
// lose a result, plus a saturating misaligned-load counter for debug.
module load_align_unit
   import load_store_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFS_W  = $clog2(DATA_W / 8),
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [OFS_W-1:0]  in_ofs,
   input  logic [1:0]        in_size,
   input  logic              in_signed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_misaligned,
   output logic [CNT_W-1:0]  misalign_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] fmtData_s;
   logic              fmtMis_s;
   logic              acc_s;
   logic              tk_s;

   skidState_t        state_r;
   logic [DATA_W-1:0] mainData_r;
   logic              mainMis_r;
   logic [DATA_W-1:0] skidData_r;
   logic              skidMis_r;
   logic [CNT_W-1:0]  count_r;

   load_lane_format #(
      .DATA_W (DATA_W),
      .OFS_W  (OFS_W)
   ) uFormat (
      .data       (in_data),
      .ofs        (in_ofs),
      .size       (in_size),
      .isSigned   (in_signed),
      .fmtData    (fmtData_s),
      .misaligned (fmtMis_s)
   );

   // Readiness depends only on skid occupancy, never on out_ready.
   assign in_ready       = (state_r != ST_FULL) && !reset;
   assign out_valid      = (state_r != ST_EMPTY);
   assign out_data       = mainData_r;
   assign out_misaligned = mainMis_r;
   assign misalign_count = count_r;
   assign acc_s          = in_valid && in_ready;
   assign tk_s           = out_valid && out_ready;

   // Skid-buffer FSM, data registers and saturating misalignment counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_EMPTY;
         mainData_r <= '0;
         mainMis_r  <= 1'b0;
         skidData_r <= '0;
         skidMis_r  <= 1'b0;
         count_r    <= '0;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (acc_s) begin
                  mainData_r <= fmtData_s;
                  mainMis_r  <= fmtMis_s;
                  state_r    <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (acc_s && tk_s) begin
                  mainData_r <= fmtData_s;
                  mainMis_r  <= fmtMis_s;
               end else if (acc_s) begin
                  skidData_r <= fmtData_s;
                  skidMis_r  <= fmtMis_s;
                  state_r    <= ST_FULL;
               end else if (tk_s) begin
                  state_r    <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (tk_s) begin
                  mainData_r <= skidData_r;
                  mainMis_r  <= skidMis_r;
                  state_r    <= ST_ONE;
               end
            end
            default: begin
               state_r <= ST_EMPTY;
            end
         endcase
         if (acc_s && fmtMis_s && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: stimulus pushes expected results on
// acceptance, a negedge monitor pops and compares every output transfer.
module tb_load_align_unit;
   import load_store_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_signed;
   logic        out_ready;
   logic [31:0] in_data;
   logic [1:0]  in_ofs;
   logic [1:0]  in_size;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_misaligned;
   logic [7:0]  misalign_count;
   logic        satInReady;
   logic        satOutValid;
   logic [31:0] satOutData;
   logic        satOutMis;
   logic [1:0]  satCount;

   typedef struct packed {
      logic [31:0] data;
      logic        mis;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   load_align_unit dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ofs(in_ofs), .in_size(in_size), .in_signed(in_signed),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_misaligned(out_misaligned), .misalign_count(misalign_count)
   );

   load_align_unit #(.CNT_W(2)) dutSat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(satInReady),
      .in_data(in_data), .in_ofs(in_ofs), .in_size(in_size), .in_signed(in_signed),
      .out_valid(satOutValid), .out_ready(out_ready), .out_data(satOutData),
      .out_misaligned(satOutMis), .misalign_count(satCount)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Output monitor: every out_valid && out_ready cycle is one transfer to score
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b0) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected no transfer", out_data);
         end else begin
            monE = expQ.pop_front();
            check("out_data", out_data, monE.data);
            check("out_misaligned", {31'b0, out_misaligned}, {31'b0, monE.mis});
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic sendLoad(input logic [31:0] d, input logic [1:0] ofs, input logic [1:0] sz,
                           input logic sg, input logic [31:0] ed, input logic em);
      int n;
      in_data   = d;
      in_ofs    = ofs;
      in_size   = sz;
      in_signed = sg;
      in_valid  = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      end else begin
         expQ.push_back({ed, em});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      in_ofs    = 2'd0;
      in_size   = SZ_WORD;
      in_signed = 1'b0;
      out_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_in_ready", {31'b0, in_ready}, 32'd0);
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_out_data", out_data, 32'h0);
      check("reset_count", {24'b0, misalign_count}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Formatting vectors, one result per cycle with out_ready high
      sendLoad(32'h80FF7F01, 2'd3, SZ_BYTE, 1'b1, 32'hFFFFFF80, 1'b0);
      check("latency_out_valid", {31'b0, out_valid}, 32'd1);
      sendLoad(32'h80FF7F01, 2'd2, SZ_HALF, 1'b0, 32'h000080FF, 1'b0);
      sendLoad(32'h80FF7F01, 2'd2, SZ_HALF, 1'b1, 32'hFFFF80FF, 1'b0);
      sendLoad(32'h80FF7F01, 2'd0, SZ_HALF, 1'b1, 32'h00007F01, 1'b0);
      sendLoad(32'h80FF7F01, 2'd1, SZ_BYTE, 1'b0, 32'h0000007F, 1'b0);
      sendLoad(32'h80FF7F01, 2'd1, SZ_BYTE, 1'b1, 32'h0000007F, 1'b0);
      sendLoad(32'h80FF7F01, 2'd2, SZ_BYTE, 1'b1, 32'hFFFFFFFF, 1'b0);
      sendLoad(32'h80FF7F01, 2'd0, SZ_WORD, 1'b1, 32'h80FF7F01, 1'b0);
      sendLoad(32'h80FF7F01, 2'd0, SZ_RSVD, 1'b1, 32'h80FF7F01, 1'b0);
      check("count_aligned", {24'b0, misalign_count}, 32'd0);
      sendLoad(32'h80FF7F01, 2'd1, SZ_HALF, 1'b1, 32'h00000000, 1'b1);
      check("count_half_mis", {24'b0, misalign_count}, 32'd1);
      sendLoad(32'h80FF7F01, 2'd2, SZ_WORD, 1'b0, 32'h00000000, 1'b1);
      check("count_word_mis", {24'b0, misalign_count}, 32'd2);
      sendLoad(32'h80FF7F01, 2'd3, SZ_HALF, 1'b0, 32'h00000000, 1'b1);
      check("count_half_ofs3", {24'b0, misalign_count}, 32'd3);

      // Backpressure: A and B fill the buffer, C must wait upstream
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b0;
      sendLoad(32'h11223344, 2'd0, SZ_WORD, 1'b0, 32'h11223344, 1'b0);
      sendLoad(32'h00AB0000, 2'd2, SZ_BYTE, 1'b0, 32'h000000AB, 1'b0);
      in_data   = 32'h0000F00D;
      in_ofs    = 2'd0;
      in_size   = SZ_HALF;
      in_signed = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_in_ready", {31'b0, in_ready}, 32'd0);
         check("stall_out_data", out_data, 32'h11223344);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      sendLoad(32'h0000F00D, 2'd0, SZ_HALF, 1'b1, 32'hFFFFF00D, 1'b0);

      // Reset while FULL discards both entries and clears the counter
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b0;
      sendLoad(32'hCAFEBABE, 2'd0, SZ_WORD, 1'b0, 32'hCAFEBABE, 1'b0);
      sendLoad(32'hDEADBEEF, 2'd0, SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("in_ready_during_reset", {31'b0, in_ready}, 32'd0);
      expQ.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_full_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_full_out_data", out_data, 32'h0);
      check("rst_full_count", {24'b0, misalign_count}, 32'd0);
      check("rst_full_sat_count", {30'b0, satCount}, 32'd0);
      @(negedge clk);
      check("after_reset_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      sendLoad(32'h12345678, 2'd2, SZ_HALF, 1'b0, 32'h00001234, 1'b0);
      check("reset_latency_out_valid", {31'b0, out_valid}, 32'd1);

      // Saturation: the CNT_W=2 instance must stop at 3
      for (int i = 1; i <= 5; i++) begin
         sendLoad(32'h55AA55AA, 2'd1, (i % 2 == 1) ? SZ_HALF : SZ_WORD, 1'b0, 32'h00000000, 1'b1);
         check("sat_count", {30'b0, satCount}, (i > 3) ? 32'd3 : i);
         check("wide_count", {24'b0, misalign_count}, i);
      end

      for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      check("drain_queue_empty", expQ.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
